// File: rtl/rxemacfilter.sv
// Receive destination-MAC filter for the Ethernet nibble datapath.
// Forwards only packets addressed to us, to broadcast, or optionally to multicast.
module rxemacfilter #(
    parameter bit ACCEPT_MULTICAST = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ce,
    input  logic        i_en,
    input  logic        i_cancel,
    input  logic [47:0] i_hw_mac,
    input  logic        i_v,
    input  logic [3:0]  i_nibble,
    output logic        o_v,
    output logic [3:0]  o_nibble,
    output logic        o_bcast,
    output logic        o_miss
);

    localparam int DEPTH = 13;

    logic             skip_q, skip_d;
    logic [3:0]       pos_q, pos_d;
    logic             match_q, match_d;
    logic             bcast_q, bcast_d;
    logic             mcast_q, mcast_d;
    logic             dec_len_q, dec_len_d;
    logic             dec_acc_q, dec_acc_d;
    logic             dec_bc_q, dec_bc_d;
    logic [DEPTH-1:0] dlv_q, dlv_d;
    logic [3:0]       dln_q [DEPTH];
    logic [3:0]       dln_d [DEPTH];
    logic             dv_q, dv_d;
    logic             gate_q, gate_d;
    logic             bcg_q, bcg_d;
    logic             ov_q, ov_d;
    logic [3:0]       on_q, on_d;
    logic             ob_q, ob_d;
    logic             om_q, om_d;

    logic       vin;
    logic       first;
    logic [7:0] mac_byte;
    logic [3:0] exp_nib;
    logic       match_n;
    logic       bcast_n;
    logic       mcast_n;
    logic       head;

    // Select the expected header nibble for the current position
    always_comb begin
        mac_byte = i_hw_mac[7:0];
        case (pos_q[3:1])
            3'd0:    mac_byte = i_hw_mac[47:40];
            3'd1:    mac_byte = i_hw_mac[39:32];
            3'd2:    mac_byte = i_hw_mac[31:24];
            3'd3:    mac_byte = i_hw_mac[23:16];
            3'd4:    mac_byte = i_hw_mac[15:8];
            default: mac_byte = i_hw_mac[7:0];
        endcase
        exp_nib = pos_q[0] ? mac_byte[7:4] : mac_byte[3:0];
    end

    // Header tracking, accept decision and delay-line input
    always_comb begin
        vin     = i_v && !skip_q && !i_cancel;
        first   = (pos_q == 4'd0);
        match_n = (first ? 1'b1 : match_q) && (i_nibble == exp_nib);
        bcast_n = (first ? 1'b1 : bcast_q) && (i_nibble == 4'hF);
        mcast_n = first ? i_nibble[0] : mcast_q;

        skip_d    = i_v && (i_cancel || skip_q);
        pos_d     = 4'd0;
        match_d   = match_q;
        bcast_d   = bcast_q;
        mcast_d   = mcast_q;
        dec_len_d = dec_len_q;
        dec_acc_d = dec_acc_q;
        dec_bc_d  = dec_bc_q;

        if (vin) begin
            pos_d = (pos_q == 4'd12) ? 4'd12 : pos_q + 4'd1;
            if (pos_q < 4'd12) begin
                match_d = match_n;
                bcast_d = bcast_n;
                mcast_d = mcast_n;
            end
            if (first) begin
                dec_len_d = 1'b0;
            end
            if (pos_q == 4'd11) begin
                dec_len_d = 1'b1;
                dec_acc_d = !i_en || match_n || bcast_n ||
                            (ACCEPT_MULTICAST && mcast_n);
                dec_bc_d  = bcast_n;
            end
        end

        if (i_cancel) begin
            match_d   = 1'b0;
            bcast_d   = 1'b0;
            mcast_d   = 1'b0;
            dec_len_d = 1'b0;
        end

        dlv_d = i_cancel ? '0 : {dlv_q[DEPTH-2:0], vin};
        dln_d[0] = i_nibble;
        for (int i = 1; i < DEPTH; i++) begin
            dln_d[i] = dln_q[i-1];
        end
    end

    // Output gate: latch the decision as each packet's head leaves the delay line
    always_comb begin
        head   = dlv_q[DEPTH-1] && !dv_q;
        dv_d   = dlv_q[DEPTH-1];
        gate_d = head ? (dec_len_q && dec_acc_q) : (dv_d && gate_q);
        bcg_d  = head ? dec_bc_q : bcg_q;
        ov_d   = dv_d && gate_d;
        ob_d   = ov_d && bcg_d;
        om_d   = head && dec_len_q && !dec_acc_q;
        on_d   = dln_q[DEPTH-1];
        if (i_cancel) begin
            dv_d   = 1'b0;
            gate_d = 1'b0;
            ov_d   = 1'b0;
            ob_d   = 1'b0;
            om_d   = 1'b0;
        end
    end

    // State registers, advanced only on the nibble-rate enable
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            skip_q    <= 1'b0;
            pos_q     <= 4'd0;
            match_q   <= 1'b0;
            bcast_q   <= 1'b0;
            mcast_q   <= 1'b0;
            dec_len_q <= 1'b0;
            dec_acc_q <= 1'b0;
            dec_bc_q  <= 1'b0;
            dlv_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dln_q[i] <= 4'd0;
            end
            dv_q      <= 1'b0;
            gate_q    <= 1'b0;
            bcg_q     <= 1'b0;
            ov_q      <= 1'b0;
            on_q      <= 4'd0;
            ob_q      <= 1'b0;
            om_q      <= 1'b0;
        end else if (i_ce) begin
            skip_q    <= skip_d;
            pos_q     <= pos_d;
            match_q   <= match_d;
            bcast_q   <= bcast_d;
            mcast_q   <= mcast_d;
            dec_len_q <= dec_len_d;
            dec_acc_q <= dec_acc_d;
            dec_bc_q  <= dec_bc_d;
            dlv_q     <= dlv_d;
            for (int i = 0; i < DEPTH; i++) begin
                dln_q[i] <= dln_d[i];
            end
            dv_q      <= dv_d;
            gate_q    <= gate_d;
            bcg_q     <= bcg_d;
            ov_q      <= ov_d;
            on_q      <= on_d;
            ob_q      <= ob_d;
            om_q      <= om_d;
        end
    end

    assign o_v      = ov_q;
    assign o_nibble = on_q;
    assign o_bcast  = ob_q;
    assign o_miss   = om_q;

endmodule

// File: tb/tb_rxemacfilter.sv
// Directed testbench for rxemacfilter.
// Two instances: multicast rejected (dut) and multicast accepted (dut_mc).
module tb_rxemacfilter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset;
    logic        i_ce;
    logic        i_en;
    logic        i_cancel;
    logic [47:0] i_hw_mac;
    logic        i_v;
    logic [3:0]  i_nibble;

    logic        o_v, o_bcast, o_miss;
    logic [3:0]  o_nibble;
    logic        m_v, m_bcast, m_miss;
    logic [3:0]  m_nibble;

    rxemacfilter #(.ACCEPT_MULTICAST(1'b0)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_en(i_en),
        .i_cancel(i_cancel), .i_hw_mac(i_hw_mac), .i_v(i_v),
        .i_nibble(i_nibble), .o_v(o_v), .o_nibble(o_nibble),
        .o_bcast(o_bcast), .o_miss(o_miss)
    );

    rxemacfilter #(.ACCEPT_MULTICAST(1'b1)) dut_mc (
        .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_en(i_en),
        .i_cancel(i_cancel), .i_hw_mac(i_hw_mac), .i_v(i_v),
        .i_nibble(i_nibble), .o_v(m_v), .o_nibble(m_nibble),
        .o_bcast(m_bcast), .o_miss(m_miss)
    );

    localparam logic [47:0] MAC     = 48'hA2_53_45_11_22_33;
    localparam logic [47:0] HDR_OK  = 48'h2A3554112233;
    localparam logic [47:0] HDR_BC  = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] HDR_BAD = 48'h2A3554112234;
    localparam logic [47:0] HDR_MC  = 48'h1000E5000010;

    int passed = 0;
    int total  = 0;

    bit         sv[$];
    logic [3:0] sn[$];
    bit         sc[$];
    logic [3:0] expq[$];

    logic       lv [1024];
    logic       lb [1024];
    logic       lm [1024];
    logic [3:0] ln [1024];
    logic       xv [1024];
    logic       xb [1024];
    logic       xm [1024];
    logic [3:0] xn [1024];
    int         lcnt;
    int         hold_bad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic logit();
        if (lcnt < 1024) begin
            lv[lcnt] = o_v;  lb[lcnt] = o_bcast; lm[lcnt] = o_miss; ln[lcnt] = o_nibble;
            xv[lcnt] = m_v;  xb[lcnt] = m_bcast; xm[lcnt] = m_miss; xn[lcnt] = m_nibble;
            lcnt++;
        end
    endtask

    task automatic clear_stim();
        sv.delete(); sn.delete(); sc.delete(); expq.delete();
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            sv.push_back(1'b0); sn.push_back(4'h0); sc.push_back(1'b0);
        end
    endtask

    // Nibble k of a packet: header nibbles first, then a fixed payload pattern
    task automatic add_pkt(input logic [47:0] hdr, input int len, input int nexp);
        logic [3:0] nb;
        for (int k = 0; k < len; k++) begin
            if (k < 12) nb = hdr[47-4*k -: 4];
            else        nb = 4'((k * 5 + 3) & 15);
            sv.push_back(1'b1); sn.push_back(nb); sc.push_back(1'b0);
            if (k < nexp) expq.push_back(nb);
        end
    endtask

    // Log index i holds outputs after the i-th enabled edge
    task automatic run(input int period);
        logic [6:0] snap;
        lcnt = 0;
        hold_bad = 0;
        for (int i = 0; i < sv.size() + 20; i++) begin
            if (i < sv.size()) begin
                i_v = sv[i]; i_nibble = sn[i]; i_cancel = sc[i];
            end else begin
                i_v = 1'b0; i_nibble = 4'h0; i_cancel = 1'b0;
            end
            i_ce = 1'b1;
            tick();
            logit();
            for (int p = 1; p < period; p++) begin
                i_ce = 1'b0;
                snap = {o_v, o_bcast, o_miss, o_nibble};
                tick();
                if ({o_v, o_bcast, o_miss, o_nibble} !== snap) hold_bad++;
            end
        end
        i_v = 1'b0; i_cancel = 1'b0; i_ce = 1'b1;
    endtask

    task automatic analyze(input bit mc, output int nv, output int first,
                           output int runs, output int nbc, output int nmiss,
                           output int fmiss, output int nbad);
        logic v, b, m, pv;
        logic [3:0] n;
        nv = 0; first = -1; runs = 0; nbc = 0; nmiss = 0; fmiss = -1; nbad = 0;
        pv = 1'b0;
        for (int i = 0; i < lcnt; i++) begin
            v = mc ? xv[i] : lv[i];
            b = mc ? xb[i] : lb[i];
            m = mc ? xm[i] : lm[i];
            n = mc ? xn[i] : ln[i];
            if (v === 1'b1) begin
                if (first < 0) first = i;
                if (pv !== 1'b1) runs++;
                if (nv >= expq.size() || n !== expq[nv]) nbad++;
                nv++;
            end
            if (b === 1'b1) nbc++;
            if (m === 1'b1) begin
                if (fmiss < 0) fmiss = i;
                nmiss++;
            end
            pv = v;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_v = 1'b1; i_nibble = 4'hF; i_ce = 1'b1;
        tick(); tick();
        total++; if (o_v !== 1'b0) $display("FAIL reset_o_v: got %b want 0", o_v); else passed++;
        total++; if (o_nibble !== 4'h0) $display("FAIL reset_o_nibble: got %h want 0", o_nibble); else passed++;
        total++; if (o_bcast !== 1'b0) $display("FAIL reset_o_bcast: got %b want 0", o_bcast); else passed++;
        total++; if (o_miss !== 1'b0) $display("FAIL reset_o_miss: got %b want 0", o_miss); else passed++;
        i_v = 1'b0; i_nibble = 4'h0;
        tick();
        i_reset = 1'b0;
        tick(); tick();
    endtask

    task automatic test_unicast();
        int nv, first, runs, nbc, nmiss, fmiss, nbad;
        clear_stim(); add_idle(2); add_pkt(HDR_OK, 128, 128);
        run(1);
        analyze(1'b0, nv, first, runs, nbc, nmiss, fmiss, nbad);
        total++; if (first !== 15) $display("FAIL uni_latency: got %0d want 15", first); else passed++;
        total++; if (nv !== 128) $display("FAIL uni_count: got %0d want 128", nv); else passed++;
        total++; if (runs !== 1) $display("FAIL uni_gapless: got %0d runs want 1", runs); else passed++;
        total++; if (nbad !== 0) $display("FAIL uni_data: got %0d bad want 0", nbad); else passed++;
        total++; if (nbc !== 0) $display("FAIL uni_bcast: got %0d want 0", nbc); else passed++;
        total++; if (nmiss !== 0) $display("FAIL uni_miss: got %0d want 0", nmiss); else passed++;
    endtask

    task automatic test_broadcast();
        int nv, first, runs, nbc, nmiss, fmiss, nbad;
        clear_stim(); add_idle(2); add_pkt(HDR_BC, 128, 128);
        run(1);
        analyze(1'b0, nv, first, runs, nbc, nmiss, fmiss, nbad);
        total++; if (nv !== 128) $display("FAIL bc_count: got %0d want 128", nv); else passed++;
        total++; if (nbc !== 128) $display("FAIL bc_flag: got %0d want 128", nbc); else passed++;
        total++; if (nbad !== 0) $display("FAIL bc_data: got %0d bad want 0", nbad); else passed++;
        total++; if (nmiss !== 0) $display("FAIL bc_miss: got %0d want 0", nmiss); else passed++;
    endtask

    task automatic test_mismatch();
        int nv, first, runs, nbc, nmiss, fmiss, nbad;
        clear_stim(); add_idle(2); add_pkt(HDR_BAD, 40, 0);
        run(1);
        analyze(1'b0, nv, first, runs, nbc, nmiss, fmiss, nbad);
        total++; if (nv !== 0) $display("FAIL mis_count: got %0d want 0", nv); else passed++;
        total++; if (nmiss !== 1) $display("FAIL mis_pulses: got %0d want 1", nmiss); else passed++;
        total++; if (fmiss !== 15) $display("FAIL mis_when: got %0d want 15", fmiss); else passed++;
        analyze(1'b1, nv, first, runs, nbc, nmiss, fmiss, nbad);
        total++; if (nv !== 0) $display("FAIL mis_mc_count: got %0d want 0", nv); else passed++;
        i_en = 1'b0;
        clear_stim(); add_idle(2); add_pkt(HDR_BAD, 40, 40);
        run(1);
        analyze(1'b0, nv, first, runs, nbc, nmiss, fmiss, nbad);
        total++; if (nv !== 40) $display("FAIL promisc_count: got %0d want 40", nv); else passed++;
        total++; if (nbad !== 0) $display("FAIL promisc_data: got %0d bad want 0", nbad); else passed++;
        total++; if (nmiss !== 0) $display("FAIL promisc_miss: got %0d want 0", nmiss); else passed++;
        i_en = 1'b1;
    endtask

    task automatic test_multicast();
        int nv, first, runs, nbc, nmiss, fmiss, nbad;
        clear_stim(); add_idle(2); add_pkt(HDR_MC, 48, 48);
        run(1);
        analyze(1'b0, nv, first, runs, nbc, nmiss, fmiss, nbad);
        total++; if (nv !== 0) $display("FAIL mc0_count: got %0d want 0", nv); else passed++;
        total++; if (nmiss !== 1) $display("FAIL mc0_miss: got %0d want 1", nmiss); else passed++;
        analyze(1'b1, nv, first, runs, nbc, nmiss, fmiss, nbad);
        total++; if (nv !== 48) $display("FAIL mc1_count: got %0d want 48", nv); else passed++;
        total++; if (nbad !== 0) $display("FAIL mc1_data: got %0d bad want 0", nbad); else passed++;
        total++; if (nmiss !== 0) $display("FAIL mc1_miss: got %0d want 0", nmiss); else passed++;
    endtask

    task automatic test_back_to_back();
        int nv, first, runs, nbc, nmiss, fmiss, nbad;
        int sp, sm;
        clear_stim(); add_idle(2);
        add_pkt(HDR_OK, 8, 0);
        add_idle(1);
        sp = sv.size();
        add_pkt(HDR_OK, 64, 64);
        add_idle(1);
        sm = sv.size();
        add_pkt(HDR_BAD, 24, 0);
        run(1);
        analyze(1'b0, nv, first, runs, nbc, nmiss, fmiss, nbad);
        total++; if (nv !== 64) $display("FAIL b2b_count: got %0d want 64", nv); else passed++;
        total++; if (runs !== 1) $display("FAIL b2b_runs: got %0d want 1", runs); else passed++;
        total++; if (first !== sp + 13) $display("FAIL b2b_first: got %0d want %0d", first, sp + 13); else passed++;
        total++; if (nbad !== 0) $display("FAIL b2b_data: got %0d bad want 0", nbad); else passed++;
        total++; if (nmiss !== 1) $display("FAIL b2b_miss: got %0d want 1", nmiss); else passed++;
        total++; if (fmiss !== sm + 13) $display("FAIL b2b_miss_when: got %0d want %0d", fmiss, sm + 13); else passed++;
    endtask

    task automatic test_cancel();
        int nv, first, runs, nbc, nmiss, fmiss, nbad;
        int s;
        clear_stim(); add_idle(2);
        s = sv.size();
        add_pkt(HDR_OK, 64, 27);
        sc[s + 40] = 1'b1;
        add_idle(2);
        add_pkt(HDR_OK, 16, 16);
        run(1);
        analyze(1'b0, nv, first, runs, nbc, nmiss, fmiss, nbad);
        total++; if (lv[s + 39] !== 1'b1) $display("FAIL cancel_before: got %b want 1", lv[s + 39]); else passed++;
        total++; if (lv[s + 40] !== 1'b0) $display("FAIL cancel_edge: got %b want 0", lv[s + 40]); else passed++;
        total++; if (nv !== 43) $display("FAIL cancel_count: got %0d want 43", nv); else passed++;
        total++; if (runs !== 2) $display("FAIL cancel_runs: got %0d want 2", runs); else passed++;
        total++; if (nbad !== 0) $display("FAIL cancel_data: got %0d bad want 0", nbad); else passed++;
        total++; if (nmiss !== 0) $display("FAIL cancel_miss: got %0d want 0", nmiss); else passed++;
    endtask

    task automatic test_ce_gating();
        int nv, first, runs, nbc, nmiss, fmiss, nbad;
        clear_stim(); add_idle(2);
        add_pkt(HDR_OK, 40, 40);
        add_idle(3);
        add_pkt(HDR_BAD, 20, 0);
        run(3);
        analyze(1'b0, nv, first, runs, nbc, nmiss, fmiss, nbad);
        total++; if (first !== 15) $display("FAIL ce_latency: got %0d want 15", first); else passed++;
        total++; if (nv !== 40) $display("FAIL ce_count: got %0d want 40", nv); else passed++;
        total++; if (nbad !== 0) $display("FAIL ce_data: got %0d bad want 0", nbad); else passed++;
        total++; if (nmiss !== 1) $display("FAIL ce_miss: got %0d want 1", nmiss); else passed++;
        total++; if (fmiss !== 58) $display("FAIL ce_miss_when: got %0d want 58", fmiss); else passed++;
        total++; if (hold_bad !== 0) $display("FAIL ce_hold: got %0d changes want 0", hold_bad); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] nb;
        int late;
        i_ce = 1'b1; i_v = 1'b0;
        tick();
        for (int k = 0; k < 30; k++) begin
            nb = (k < 12) ? HDR_OK[47-4*k -: 4] : 4'((k * 5 + 3) & 15);
            i_v = 1'b1; i_nibble = nb;
            tick();
        end
        total++; if (o_v !== 1'b1) $display("FAIL rstmid_pre: got %b want 1", o_v); else passed++;
        i_reset = 1'b1; i_nibble = 4'h7;
        tick();
        total++; if (o_v !== 1'b0) $display("FAIL rstmid_o_v: got %b want 0", o_v); else passed++;
        total++; if (o_nibble !== 4'h0) $display("FAIL rstmid_o_nibble: got %h want 0", o_nibble); else passed++;
        total++; if ({o_bcast, o_miss} !== 2'b00) $display("FAIL rstmid_flags: got %b want 00", {o_bcast, o_miss}); else passed++;
        i_reset = 1'b0; i_v = 1'b0;
        late = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_v === 1'b1) late++;
        end
        total++; if (late !== 0) $display("FAIL rstmid_drain: got %0d want 0", late); else passed++;
    endtask

    initial begin
        i_reset = 1'b1; i_ce = 1'b1; i_en = 1'b1; i_cancel = 1'b0;
        i_hw_mac = MAC; i_v = 1'b0; i_nibble = 4'h0;
        test_reset();
        test_unicast();
        test_broadcast();
        test_mismatch();
        test_multicast();
        test_back_to_back();
        test_cancel();
        test_ce_gating();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rxemacfilter.md
# rxemacfilter

Receive-side destination-MAC filter for the Ethernet nibble datapath. Sits between the RX preamble/CRC stages and the RX packet buffer. Checks the first six bytes (destination MAC) of every packet against the device hardware MAC and the broadcast address, optionally accepts multicast, and forwards only accepted packets, whole and unmodified. Rejected packets never assert `o_v`.

## Interface

**Parameters**

- `ACCEPT_MULTICAST`, default 0: when 1, accept any packet whose first destination byte has bit 0 set, i.e. bit 0 of the first received nibble.

**Ports**

- `i_clk`  in  1: system clock. All logic runs on its rising edge.
- `i_reset`  in  1: synchronous, active-high reset.
- `i_ce`  in  1: nibble-rate clock enable. All state holds when low.
- `i_en`  in  1: filter enable. When 0 (promiscuous), every packet of 12 or more nibbles is passed.
- `i_cancel`  in  1: abort the packet in flight.
- `i_hw_mac`  in  48: device MAC. `[47:40]` is the first byte on the wire.
- `i_v`  in  1: input nibble valid. High and contiguous for one packet.
- `i_nibble`  in  4: input nibble. Each byte arrives low nibble first.
- `o_v`  out  1: output nibble valid.
- `o_nibble`  out  4: output nibble.
- `o_bcast`  out  1: high alongside `o_v` while the forwarded packet is broadcast.
- `o_miss`  out  1: one-`i_ce` pulse per packet rejected by the address filter.

## Operation

**Reset.** `i_reset` clears `o_v`, `o_nibble`, `o_bcast`, `o_miss`, the delay line, the position counter and all match flags to 0.

**Packet boundaries.**
- A packet starts on the first `i_ce` cycle with `i_v`=1 after a cycle with `i_v`=0.
- It ends when `i_v` falls.

**Header comparison.**
- Position counter `pos` runs 0..12 and saturates at 12.
- The expected nibble at `pos`=2j is `i_hw_mac[47-8j-4 -: 4]` (low nibble of byte j). At `pos`=2j+1 it is `i_hw_mac[47-8j -: 4]` (high nibble).
- Three running flags are kept:
  - `match`: every nibble so far equals the expected nibble.
  - `bcast`: every nibble so far is 4'hF.
  - `mcast`: nibble 0, bit 0 is set.
- Decision at the 12th nibble: accept = `!i_en` OR `match` OR `bcast` OR (`ACCEPT_MULTICAST` AND `mcast`).
- `i_hw_mac` is sampled continuously. Changing it mid-header is undefined for that packet only.

**Delay line.**
- Each `i_ce` cycle shifts `{i_v, i_nibble}` into a 13-stage delay line.
- Each packet's accept decision is latched into a gate register when that packet's first nibble reaches the output.
- The gate is held until the delayed valid falls.
- `o_v` = delayed valid AND gate. `o_nibble` = delayed nibble, passed even when `o_v`=0.

**Runts.** A packet with fewer than 12 nibbles is never forwarded and does not pulse `o_miss`.

**`o_miss`.**
- Pulses for exactly one `i_ce` cycle, in the cycle where a rejected packet's first nibble would have appeared on the output.
- Never pulses when `i_en`=0.

**`i_cancel`.**
- Same-cycle effect: `o_v`=0 and `o_bcast`=0 on the next `i_ce` edge.
- Clears all delayed valids and resets `pos` and the flags. Nothing from a cancelled packet is output afterwards.
- A new packet is recognised only after `i_v` has been observed low.

**Back-to-back packets.**
- An inter-packet gap of 1 `i_ce` cycle or more must be handled.
- The tail of packet A drains with A's gate. Packet B's head uses B's own decision.

## Timing

- Latency: a nibble sampled on `i_ce` edge k appears on `o_nibble` and `o_v` after `i_ce` edge k+13.
- Throughput is one nibble per `i_ce`, with no stalls and no packet-length limit.
- Output pacing: with `i_ce` low, outputs hold their values. `o_miss` stays high until the next `i_ce` edge.
- Accepted packets come out with the same length and nibble order as they went in, and no gaps.
- Simultaneous `i_cancel` and `i_reset`: reset dominates, and both clear the block.
- `i_cancel` together with `i_v` rising: that nibble is discarded.

## Test plan

The hardware MAC for all scenarios is `i_hw_mac`=48'hA2_53_45_11_22_33, with `i_en`=1 and `i_ce`=1 unless stated. The matching destination header is nibbles 2,A,3,5,5,4,1,1,2,2,3,3.

1. **Unicast match.** Send a 128-nibble packet with the matching header. Required: `o_v` rises 13 cycles after the first `i_v`, and all 128 nibbles come out identical. `o_bcast`=0 and `o_miss` stays 0.
2. **Broadcast.** Send a 128-nibble packet with 12×F. Required: the packet is forwarded, and `o_bcast`=1 for all 128 valid cycles.
3. **Mismatch.**
   - Send a header whose last nibble is 4 instead of 3. Required: `o_v` never rises, and `o_miss` pulses once, 13 cycles after the first nibble.
   - Repeat with `i_en`=0. Required: the packet is forwarded and `o_miss`=0.
4. **Multicast.**
   - Send a header starting with nibble 1 (e.g. 01:00:5E:…) with `ACCEPT_MULTICAST`=0. Required: rejected.
   - Repeat with `ACCEPT_MULTICAST`=1. Required: forwarded.
5. **Runt and back-to-back.**
   - Send an 8-nibble runt, a 1-cycle gap, then a matching 64-nibble packet, then a 1-cycle gap and a mismatching packet. Required: only the 64-nibble packet appears, and `o_miss` pulses once.
6. **Cancel, `i_ce` gating and reset.**
   - Assert `i_cancel` at nibble 40 of a matching packet. Required: `o_v`=0 from the next edge, with no further output.
   - Toggle `i_ce` at 1-in-3. Required: identical output, with latency counted in `i_ce` edges.
   - Assert `i_reset` mid-packet. Required: all outputs are 0 on the next edge.
